// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared processor types for the fetch / load-store bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_LSM = 1'b1
  } grant_t;

  localparam int unsigned MAX_CONSEC_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master (fetch, load/store) arbiter onto one pipelined
//               Wishbone port, with starvation protection for fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = MAX_CONSEC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        lsm_req_i,
  input  logic        lsm_we_i,
  input  logic [3:0]  lsm_sel_i,
  input  logic [31:0] lsm_addr_i,
  input  logic [31:0] lsm_data_i,
  output logic        lsm_ack_o,
  output logic [31:0] lsm_data_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_REQUEST  = REQUEST;
  localparam logic [1:0] S_WAIT_ACK = WAIT_ACK;
  localparam logic [1:0] S_DONE     = DONE;
  localparam logic [2:0] C_MAX_CNT  = 3'(MAX_CONSEC);

  logic [1:0]  state_q,    state_d;
  logic [2:0]  cnt_q,      cnt_d;
  grant_t      grant_q,    grant_d;
  logic [31:0] adr_q,      adr_d;
  logic [31:0] dat_q,      dat_d;
  logic        we_q,       we_d;
  logic [3:0]  sel_q,      sel_d;
  logic        stb_q,      stb_d;
  logic        cyc_q,      cyc_d;
  logic        if_ack_q,   if_ack_d;
  logic        lsm_ack_q,  lsm_ack_d;
  logic [31:0] if_data_q,  if_data_d;
  logic [31:0] lsm_data_q, lsm_data_d;

  logic w_grant_if;
  logic w_done;

  // Fetch only beats a concurrent load/store once it has waited MAX_CONSEC grants
  assign w_grant_if = if_req_i && (!lsm_req_i || (cnt_q == C_MAX_CNT));
  assign w_done     = ((state_q == S_REQUEST) && !wb_stall_i && wb_ack_i) ||
                      ((state_q == S_WAIT_ACK) && wb_ack_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    if_ack_d   = 1'b0;
    lsm_ack_d  = 1'b0;
    if_data_d  = if_data_q;
    lsm_data_d = lsm_data_q;

    case (state_q)
      S_IDLE: begin
        if (if_req_i || lsm_req_i) begin
          if (w_grant_if) begin
            grant_d = GRANT_IF;
            adr_d   = if_addr_i;
            dat_d   = 32'd0;
            we_d    = 1'b0;
            sel_d   = 4'hF;
            cnt_d   = 3'd0;
          end else begin
            grant_d = GRANT_LSM;
            adr_d   = lsm_addr_i;
            dat_d   = lsm_data_i;
            we_d    = lsm_we_i;
            sel_d   = lsm_sel_i;
            if (!if_req_i)                cnt_d = 3'd0;
            else if (cnt_q != C_MAX_CNT)  cnt_d = cnt_q + 3'd1;
          end
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        stb_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion overrides the REQUEST/WAIT_ACK transitions above
    if (w_done) begin
      state_d = S_DONE;
      stb_d   = 1'b0;
      cyc_d   = 1'b0;
      if (grant_q == GRANT_IF) begin
        if_ack_d  = 1'b1;
        if_data_d = wb_dat_i;
      end else begin
        lsm_ack_d  = 1'b1;
        lsm_data_d = wb_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      grant_q    <= GRANT_IF;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      if_ack_q   <= 1'b0;
      lsm_ack_q  <= 1'b0;
      if_data_q  <= 32'd0;
      lsm_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      if_ack_q   <= if_ack_d;
      lsm_ack_q  <= lsm_ack_d;
      if_data_q  <= if_data_d;
      lsm_data_q <= lsm_data_d;
    end
  end

  assign if_ack_o   = if_ack_q;
  assign if_data_o  = if_data_q;
  assign lsm_ack_o  = lsm_ack_q;
  assign lsm_data_o = lsm_data_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = cyc_q;

endmodule

`default_nettype wire
